// File: rtl/operand_fwd_stage_pkg.sv
// operand_fwd_stage_pkg: operand select and forward-source encodings
package operand_fwd_stage_pkg;
  typedef logic [1:0] sel_t;
  localparam sel_t ALU_A_PC   = 2'b00;
  localparam sel_t ALU_A_RS1  = 2'b01;
  localparam sel_t ALU_A_ZERO = 2'b10;
  localparam sel_t ALU_B_RS2  = 2'b00;
  localparam sel_t ALU_B_IMM  = 2'b01;
  localparam sel_t ALU_B_FOUR = 2'b10;
  localparam sel_t FWD_NONE   = 2'b00;
  localparam sel_t FWD_EX     = 2'b01;
  localparam sel_t FWD_WB     = 2'b10;
endpackage

// File: rtl/operand_fwd_stage_if.sv
// operand_fwd_stage_if: upstream operand bus, bypass buses and registered operand outputs
interface operand_fwd_stage_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [XLEN-1:0]   pc, rd1, rd2, imm, ex_data, wb_data, op_a, op_b, store_data;
  logic [REG_AW-1:0] rs1, rs2, ex_rd, wb_rd;
  logic [1:0]        sel_a, sel_b, fwd_a, fwd_b;
  logic              ex_we, wb_we;
  modport master (
    output in_valid, pc, rd1, rd2, imm, rs1, rs2, sel_a, sel_b,
           ex_we, ex_rd, ex_data, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, op_a, op_b, store_data, fwd_a, fwd_b
  );
  modport slave (
    input  in_valid, pc, rd1, rd2, imm, rs1, rs2, sel_a, sel_b,
           ex_we, ex_rd, ex_data, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, op_a, op_b, store_data, fwd_a, fwd_b
  );
endinterface

// File: rtl/operand_fwd_stage_fwd_select.sv
// fwd_select: picks a source register value from EX, WB or the register file (EX first, x0 never)
import operand_fwd_stage_pkg::*;
module fwd_select #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rd,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   val,
  output logic [1:0]        src
);
  logic ex_hit, wb_hit;
  always_comb begin
    ex_hit = FWD_EN && ex_we && ex_rd == rs && rs != '0;
    wb_hit = FWD_EN && wb_we && wb_rd == rs && rs != '0;
    val = ex_hit ? ex_data : wb_hit ? wb_data : rd;
    src = ex_hit ? FWD_EX : wb_hit ? FWD_WB : FWD_NONE;
  end
endmodule

// File: rtl/operand_fwd_stage.sv
// operand_fwd_stage: forwards rs1/rs2, selects ALU operands and registers them behind valid/ready
import operand_fwd_stage_pkg::*;
module operand_fwd_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1
) (
  input logic clk,
  input logic rst_n,
  operand_fwd_stage_if.slave bus
);
  logic [XLEN-1:0] v1, v2, a_n, b_n;
  logic [1:0]      s1, s2;
  logic            capture;
  fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_rs1 (
    .rs(bus.rs1), .rd(bus.rd1), .ex_we(bus.ex_we), .ex_rd(bus.ex_rd), .ex_data(bus.ex_data),
    .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data), .val(v1), .src(s1)
  );
  fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_rs2 (
    .rs(bus.rs2), .rd(bus.rd2), .ex_we(bus.ex_we), .ex_rd(bus.ex_rd), .ex_data(bus.ex_data),
    .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data), .val(v2), .src(s2)
  );
  always_comb begin
    a_n = bus.sel_a == ALU_A_PC ? bus.pc : bus.sel_a == ALU_A_RS1 ? v1 : '0;
    b_n = bus.sel_b == ALU_B_RS2 ? v2 : bus.sel_b == ALU_B_IMM ? bus.imm :
          bus.sel_b == ALU_B_FOUR ? XLEN'(4) : '0;
    bus.in_ready = !bus.out_valid || bus.out_ready;
    capture = bus.in_valid && bus.in_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.op_a       <= '0;
      bus.op_b       <= '0;
      bus.store_data <= '0;
      bus.fwd_a      <= FWD_NONE;
      bus.fwd_b      <= FWD_NONE;
    end else begin
      // flush only kills valid; whatever the data regs load is never observed
      bus.out_valid <= !bus.flush && (capture || (bus.out_valid && !bus.out_ready));
      if (capture) begin
        bus.op_a       <= a_n;
        bus.op_b       <= b_n;
        bus.store_data <= v2;
        bus.fwd_a      <= bus.sel_a == ALU_A_RS1 ? s1 : FWD_NONE;
        bus.fwd_b      <= bus.sel_b == ALU_B_RS2 ? s2 : FWD_NONE;
      end
    end
  end
endmodule

// File: tb/tb_operand_fwd_stage.sv
// tb_operand_fwd_stage: directed and random checks against a behavioural operand-stage model
module tb_operand_fwd_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n = 0, err = 0;
  operand_fwd_stage_if #(.XLEN(32), .REG_AW(5)) bus ();
  operand_fwd_stage #(.XLEN(32), .REG_AW(5), .FWD_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic        m_valid = 1'b0, m_known = 1'b1;
  logic [31:0] m_a = 0, m_b = 0, m_s = 0;
  logic [1:0]  m_fa = 0, m_fb = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // source of a register read: 0 regfile, 1 EX, 2 WB
  function automatic int src_of(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (bus.ex_we && bus.ex_rd == rs) return 1;
    if (bus.wb_we && bus.wb_rd == rs) return 2;
    return 0;
  endfunction
  function automatic logic [31:0] read_reg(input logic [4:0] rs, input logic [31:0] rf);
    case (src_of(rs))
      1: return bus.ex_data;
      2: return bus.wb_data;
      default: return rf;
    endcase
  endfunction
  task automatic tick();
    logic rdy, cap;
    #1;
    rdy = !m_valid || bus.out_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_s = 0; m_fa = 0; m_fb = 0; m_known = 1;
    end else begin
      cap = bus.in_valid && rdy;
      if (cap) begin
        case (bus.sel_a)
          0: m_a = bus.pc;
          1: m_a = read_reg(bus.rs1, bus.rd1);
          default: m_a = 0;
        endcase
        case (bus.sel_b)
          0: m_b = read_reg(bus.rs2, bus.rd2);
          1: m_b = bus.imm;
          2: m_b = 4;
          default: m_b = 0;
        endcase
        m_s  = read_reg(bus.rs2, bus.rd2);
        m_fa = bus.sel_a == 1 ? 2'(src_of(bus.rs1)) : 2'd0;
        m_fb = bus.sel_b == 0 ? 2'(src_of(bus.rs2)) : 2'd0;
        m_known = !bus.flush;
      end else if (bus.flush) m_known = 0;
      m_valid = !bus.flush && (cap || (m_valid && !bus.out_ready));
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_known) begin
      chk("op_a", bus.op_a, m_a);
      chk("op_b", bus.op_b, m_b);
      chk("store_data", bus.store_data, m_s);
      chk("fwd_a", 32'(bus.fwd_a), 32'(m_fa));
      chk("fwd_b", 32'(bus.fwd_b), 32'(m_fb));
    end
  endtask
  task automatic clear();
    {bus.in_valid, bus.pc, bus.rd1, bus.rd2, bus.imm, bus.rs1, bus.rs2, bus.sel_a, bus.sel_b} = '0;
    {bus.ex_we, bus.ex_rd, bus.ex_data, bus.wb_we, bus.wb_rd, bus.wb_data, bus.flush} = '0;
    bus.out_ready = 1'b1;
  endtask
  initial begin
    clear();
    // reset held two cycles with traffic offered
    bus.in_valid = 1; bus.rd1 = 32'h55;
    tick(); tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_op_a", bus.op_a, 32'd0);
    chk("t1_op_b", bus.op_b, 32'd0);
    rst_n = 1; #1;
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    // no hazard
    clear(); bus.in_valid = 1; bus.sel_a = 1; bus.sel_b = 1; bus.rd1 = 32'h10; bus.imm = 32'hFFFF_FFF0;
    tick();
    chk("t2_op_a", bus.op_a, 32'h10);
    chk("t2_op_b", bus.op_b, 32'hFFFF_FFF0);
    chk("t2_fwd_a", 32'(bus.fwd_a), 32'd0);
    // EX beats WB; x0 never forwarded
    clear(); bus.in_valid = 1; bus.sel_a = 1; bus.rs1 = 5; bus.rd1 = 32'h77;
    bus.ex_we = 1; bus.ex_rd = 5; bus.ex_data = 32'hAAAA; bus.wb_we = 1; bus.wb_rd = 5; bus.wb_data = 32'hBBBB;
    tick();
    chk("t3_op_a", bus.op_a, 32'hAAAA);
    chk("t3_fwd_a", 32'(bus.fwd_a), 32'd1);
    bus.rs1 = 0; bus.ex_rd = 0; bus.wb_rd = 0;
    tick();
    chk("t3_x0_op_a", bus.op_a, 32'h77);
    chk("t3_x0_fwd_a", 32'(bus.fwd_a), 32'd0);
    // store data forwarded from WB while op_b takes imm
    clear(); bus.in_valid = 1; bus.sel_b = 1; bus.imm = 32'h24; bus.rs2 = 7; bus.rd2 = 32'h9;
    bus.wb_we = 1; bus.wb_rd = 7; bus.wb_data = 32'h1234;
    tick();
    chk("t4_op_b", bus.op_b, 32'h24);
    chk("t4_store", bus.store_data, 32'h1234);
    chk("t4_fwd_b", 32'(bus.fwd_b), 32'd0);
    // stall with changing inputs, then release
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.imm = 32'h100 + 32'(i); bus.rd2 = 32'h200 + 32'(i);
      tick();
      chk("t5_hold_b", bus.op_b, 32'h24);
    end
    bus.out_ready = 1;
    tick();
    chk("t5_new_b", bus.op_b, 32'h102);
    // flush wins over capture
    bus.flush = 1;
    tick();
    chk("t6_flush_valid", 32'(bus.out_valid), 32'd0);
    clear(); bus.in_valid = 1; bus.sel_a = 0; bus.sel_b = 2; bus.pc = 32'h80;
    tick();
    chk("t6_op_a", bus.op_a, 32'h80);
    chk("t6_op_b", bus.op_b, 32'd4);
    // random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush = $urandom_range(0, 15) == 0;
      rst_n = $urandom_range(0, 40) != 0;
      bus.pc = $urandom; bus.rd1 = $urandom; bus.rd2 = $urandom; bus.imm = $urandom;
      bus.rs1 = 5'($urandom_range(0, 3)); bus.rs2 = 5'($urandom_range(0, 3));
      bus.sel_a = 2'($urandom); bus.sel_b = 2'($urandom);
      bus.ex_we = 1'($urandom); bus.ex_rd = 5'($urandom_range(0, 3)); bus.ex_data = $urandom;
      bus.wb_we = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
